letter_sequence_arbiter: RTL and testbench

Frame-synchronous N-channel arbiter for on-screen letter sequences in the game menus. It selects one of NUM_SEQ requesting text sequences by fixed priority, at frame boundaries only. It drives a single registered position/letter bundle to the letter drawing object. An optional typewriter effect reveals the selected sequence one letter at a time.

---
 rtl/letter_seq_pkg.sv | 18 +
 rtl/letter_reveal_counter.sv | 52 +++++
 rtl/letter_sequence_arbiter.sv | 162 ++++++++++++++++
 tb/tb_letter_sequence_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/letter_seq_pkg.sv
// Shared types and constants for the menu letter-sequence arbiter.
package letter_seq_pkg;

    localparam int LETTER_W_C = 5;
    localparam int COORD_W_C  = 11;

    typedef logic [LETTER_W_C-1:0] letter_t;
    typedef logic [COORD_W_C-1:0]  coord_t;

    localparam letter_t BLANK_LETTER = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REVEAL = 2'd1,
        SHOWN  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/letter_reveal_counter.sv
// Typewriter pacing: counts frames per letter and the number of visible letters.
// done is high when the next advance makes every letter visible.
module letter_reveal_counter #(
    parameter int SEQ_LEN       = 16,
    parameter int REVEAL_FRAMES = 4,
    localparam int VIS_W        = $clog2(SEQ_LEN + 1),
    localparam int FRAME_W      = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             restart,
    input  logic             advance,
    output logic [VIS_W-1:0] vis_cnt_next,
    output logic             done
);

    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [VIS_W-1:0]   vis_cnt_q, vis_cnt_d;
    logic               last_frame;

    assign last_frame = (frame_cnt_q == FRAME_W'(REVEAL_FRAMES - 1));

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        vis_cnt_d   = vis_cnt_q;
        if (restart) begin
            frame_cnt_d = '0;
            vis_cnt_d   = '0;
        end else if (advance && (vis_cnt_q != VIS_W'(SEQ_LEN))) begin
            if (last_frame) begin
                frame_cnt_d = '0;
                vis_cnt_d   = vis_cnt_q + 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt_q <= '0;
            vis_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            vis_cnt_q   <= vis_cnt_d;
        end
    end

    assign vis_cnt_next = vis_cnt_d;
    assign done         = last_frame && (vis_cnt_q == VIS_W'(SEQ_LEN - 1));

endmodule

// File: rtl/letter_sequence_arbiter.sv
// Frame-synchronous fixed-priority arbiter for on-screen letter sequences.
// Define LETTER_SEQ_TYPEWRITER_EN to reveal the selected sequence one letter at a time.
module letter_sequence_arbiter
    import letter_seq_pkg::*;
#(
    parameter int NUM_SEQ       = 4,
    parameter int SEQ_LEN       = 16,
    parameter int LETTER_W      = LETTER_W_C,
    parameter int COORD_W       = COORD_W_C,
    parameter int REVEAL_FRAMES = 4,
    localparam int SEL_W        = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1
) (
    input  logic                                clk,
    input  logic                                resetN,
    input  logic                                startOfFrame,
    input  logic [NUM_SEQ-1:0]                  seq_req,
    input  logic [NUM_SEQ*COORD_W-1:0]          seq_x,
    input  logic [NUM_SEQ*COORD_W-1:0]          seq_y,
    input  logic [NUM_SEQ*SEQ_LEN*LETTER_W-1:0] seq_letters,
    output logic [COORD_W-1:0]                  X_OUT,
    output logic [COORD_W-1:0]                  Y_OUT,
    output logic [SEQ_LEN*LETTER_W-1:0]         letters_out,
    output logic                                SEQ_OUT,
    output logic [SEL_W-1:0]                    sel_idx,
    output logic                                reveal_done
);

    arb_state_t                  state_q, state_d;
    logic [SEL_W-1:0]            sel_q, sel_d, winner;
    logic                        any_req;
    logic [COORD_W-1:0]          x_q, x_d, y_q, y_d;
    logic [SEQ_LEN*LETTER_W-1:0] letters_q, letters_d;
    logic                        seq_out_q, seq_out_d;
    logic                        done_q, done_d;
    logic [SEQ_LEN-1:0]          vis_mask;

    logic [COORD_W-1:0]          ch_x       [NUM_SEQ];
    logic [COORD_W-1:0]          ch_y       [NUM_SEQ];
    logic [SEQ_LEN*LETTER_W-1:0] ch_letters [NUM_SEQ];

    for (genvar gi = 0; gi < NUM_SEQ; gi++) begin : g_chan
        assign ch_x[gi]       = seq_x[gi*COORD_W +: COORD_W];
        assign ch_y[gi]       = seq_y[gi*COORD_W +: COORD_W];
        assign ch_letters[gi] = seq_letters[gi*SEQ_LEN*LETTER_W +: SEQ_LEN*LETTER_W];
    end

    // An out-of-range pacing value elaborates this marker scope so it shows up in the hierarchy.
    if (REVEAL_FRAMES < 1) begin : g_bad_reveal_frames
    end

    assign any_req = |seq_req;

    always_comb begin
        winner = '0;
        for (int c = NUM_SEQ - 1; c >= 0; c--) begin
            if (seq_req[c]) winner = SEL_W'(c);
        end
    end

`ifdef LETTER_SEQ_TYPEWRITER_EN
    localparam int VIS_W = $clog2(SEQ_LEN + 1);

    logic             restart, advance, reveal_last;
    logic [VIS_W-1:0] vis_next;

    letter_reveal_counter #(
        .SEQ_LEN      (SEQ_LEN),
        .REVEAL_FRAMES(REVEAL_FRAMES)
    ) u_reveal (
        .clk         (clk),
        .resetN      (resetN),
        .restart     (restart),
        .advance     (advance),
        .vis_cnt_next(vis_next),
        .done        (reveal_last)
    );

    always_comb begin
        vis_mask = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            vis_mask[i] = (state_d == SHOWN) || (VIS_W'(i) < vis_next);
        end
    end
`else
    assign vis_mask = '1;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
`ifdef LETTER_SEQ_TYPEWRITER_EN
        restart = 1'b0;
        advance = 1'b0;
`endif
        if (startOfFrame) begin
            if (!any_req) begin
                state_d = IDLE;
                sel_d   = '0;
            end else if ((state_q == IDLE) || (winner != sel_q)) begin
                sel_d = winner;
`ifdef LETTER_SEQ_TYPEWRITER_EN
                state_d = REVEAL;
                restart = 1'b1;
`else
                state_d = SHOWN;
`endif
            end
`ifdef LETTER_SEQ_TYPEWRITER_EN
            else if (state_q == REVEAL) begin
                advance = 1'b1;
                if (reveal_last) state_d = SHOWN;
            end
`endif
        end
    end

    // Outputs are built from next-state values so a frame-start decision lands one edge later.
    always_comb begin
        x_d       = '0;
        y_d       = '0;
        letters_d = '0;
        seq_out_d = 1'b0;
        done_d    = 1'b0;
        if (state_d != IDLE) begin
            seq_out_d = 1'b1;
            done_d    = (state_d == SHOWN);
            x_d       = ch_x[sel_d];
            y_d       = ch_y[sel_d];
            for (int i = 0; i < SEQ_LEN; i++) begin
                if (vis_mask[i]) letters_d[i*LETTER_W +: LETTER_W] = ch_letters[sel_d][i*LETTER_W +: LETTER_W];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            letters_q <= '0;
            seq_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            x_q       <= x_d;
            y_q       <= y_d;
            letters_q <= letters_d;
            seq_out_q <= seq_out_d;
            done_q    <= done_d;
        end
    end

    assign X_OUT       = x_q;
    assign Y_OUT       = y_q;
    assign letters_out = letters_q;
    assign SEQ_OUT     = seq_out_q;
    assign sel_idx     = sel_q;
    assign reveal_done = done_q;

endmodule

// File: tb/tb_letter_sequence_arbiter.sv
// Randomized self-checking bench for letter_sequence_arbiter against a frame-count reference model.
module tb_letter_sequence_arbiter;

    localparam int NS = 3;
    localparam int SL = 4;
    localparam int LW = 5;
    localparam int CW = 11;
    localparam int RF = 2;
    localparam int BW = 2*CW + SL*LW + 1 + 2 + 1;
`ifdef LETTER_SEQ_TYPEWRITER_EN
    localparam bit TW = 1'b1;
`else
    localparam bit TW = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  resetN = 1'b0;
    logic                  startOfFrame = 1'b0;
    logic [NS-1:0]         seq_req = '0;
    logic [NS*CW-1:0]      seq_x = '0;
    logic [NS*CW-1:0]      seq_y = '0;
    logic [NS*SL*LW-1:0]   seq_letters = '0;
    logic [CW-1:0]         X_OUT, Y_OUT;
    logic [SL*LW-1:0]      letters_out;
    logic                  SEQ_OUT;
    logic [1:0]            sel_idx;
    logic                  reveal_done;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    letter_sequence_arbiter #(
        .NUM_SEQ(NS), .SEQ_LEN(SL), .LETTER_W(LW), .COORD_W(CW), .REVEAL_FRAMES(RF)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .seq_req(seq_req),
        .seq_x(seq_x), .seq_y(seq_y), .seq_letters(seq_letters),
        .X_OUT(X_OUT), .Y_OUT(Y_OUT), .letters_out(letters_out), .SEQ_OUT(SEQ_OUT),
        .sel_idx(sel_idx), .reveal_done(reveal_done)
    );

    wire [BW-1:0] got = {X_OUT, Y_OUT, letters_out, SEQ_OUT, sel_idx, reveal_done};

    // Reference model: which channel is shown and how many frame starts since it was chosen.
    logic m_active;
    int   m_sel;
    int   m_frames;

    function automatic int lowest_req(input logic [NS-1:0] r);
        for (int c = 0; c < NS; c++) if (r[c]) return c;
        return 0;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_active <= 1'b0; m_sel <= 0; m_frames <= 0;
        end else if (startOfFrame) begin
            if (seq_req == '0) begin
                m_active <= 1'b0; m_sel <= 0; m_frames <= 0;
            end else if (!m_active || lowest_req(seq_req) != m_sel) begin
                m_active <= 1'b1; m_sel <= lowest_req(seq_req); m_frames <= 0;
            end else if (m_frames < SL*RF) begin
                m_frames <= m_frames + 1;
            end
        end
    end

    function automatic int visible_count();
        if (!m_active) return 0;
        if (!TW) return SL;
        return (m_frames / RF < SL) ? m_frames / RF : SL;
    endfunction

    function automatic logic [BW-1:0] exp_bundle();
        logic [CW-1:0]    x, y;
        logic [SL*LW-1:0] l;
        int               n;
        x = '0; y = '0; l = '0;
        n = visible_count();
        if (m_active) begin
            x = seq_x[m_sel*CW +: CW];
            y = seq_y[m_sel*CW +: CW];
            for (int i = 0; i < n; i++) l[i*LW +: LW] = seq_letters[(m_sel*SL + i)*LW +: LW];
        end
        return {x, y, l, m_active, (m_active ? 2'(m_sel) : 2'd0), (m_active && n == SL)};
    endfunction

    task automatic rand_contents();
        for (int c = 0; c < NS; c++) begin
            seq_x[c*CW +: CW] = CW'($urandom);
            seq_y[c*CW +: CW] = CW'($urandom);
            for (int i = 0; i < SL; i++) seq_letters[(c*SL + i)*LW +: LW] = LW'($urandom_range(1, 31));
        end
    endtask

    task automatic frame_pulse();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0; seq_req = 3'b111; rand_contents();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (got !== '0) begin tests_failed++; $display("FAIL reset_hold got=%h expected=0", got); end
        end
        resetN = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (got !== '0) begin tests_failed++; $display("FAIL reset_no_arb got=%h expected=0", got); end
        frame_pulse();
        tests_run++;
        if (sel_idx !== 2'd0 || SEQ_OUT !== 1'b1) begin
            tests_failed++; $display("FAIL reset_first_sof sel=%0d seq_out=%b expected sel=0 seq_out=1", sel_idx, SEQ_OUT);
        end
        tests_run++;
        if (got !== exp_bundle()) begin tests_failed++; $display("FAIL reset_bundle got=%h expected=%h", got, exp_bundle()); end
        $display("[TB] reset: sel=%0d seq_out=%b", sel_idx, SEQ_OUT);
    endtask

    task automatic test_priority();
        seq_req = 3'b110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (sel_idx !== 2'd0) begin tests_failed++; $display("FAIL prio_midframe sel=%0d expected=0", sel_idx); end
        end
        frame_pulse();
        tests_run++;
        if (sel_idx !== 2'd1 || X_OUT !== seq_x[CW +: CW]) begin
            tests_failed++; $display("FAIL prio_sof sel=%0d x=%h expected sel=1 x=%h", sel_idx, X_OUT, seq_x[CW +: CW]);
        end
        $display("[TB] priority: sel=%0d x=%h", sel_idx, X_OUT);
    endtask

    task automatic test_reveal();
        logic [SL*LW-1:0] exp_l;
        int n;
        seq_req = 3'b001;
        for (int i = 0; i < SL; i++) seq_letters[i*LW +: LW] = LW'(7 + i);
        frame_pulse();
        for (int k = 0; k <= SL*RF; k++) begin
            n = TW ? ((k / RF < SL) ? k / RF : SL) : SL;
            exp_l = '0;
            for (int i = 0; i < n; i++) exp_l[i*LW +: LW] = LW'(7 + i);
            tests_run++;
            if (letters_out !== exp_l || reveal_done !== (n == SL)) begin
                tests_failed++;
                $display("FAIL reveal_k%0d letters=%h done=%b expected letters=%h done=%b", k, letters_out, reveal_done, exp_l, n == SL);
            end
            $display("[TB] reveal: after %0d frames letters=%h done=%b", k, letters_out, reveal_done);
            if (k < SL*RF) frame_pulse();
        end
    endtask

    task automatic test_preempt();
        seq_req = 3'b100;
        frame_pulse();
        repeat (SL*RF) frame_pulse();
        tests_run++;
        if (sel_idx !== 2'd2 || reveal_done !== 1'b1) begin
            tests_failed++; $display("FAIL preempt_shown sel=%0d done=%b expected sel=2 done=1", sel_idx, reveal_done);
        end
        @(negedge clk);
        seq_req = 3'b101;
        repeat (2) @(negedge clk);
        frame_pulse();
        tests_run++;
        if (sel_idx !== 2'd0 || letters_out !== (TW ? '0 : seq_letters[0 +: SL*LW]) || reveal_done !== !TW) begin
            tests_failed++; $display("FAIL preempt_switch sel=%0d letters=%h done=%b", sel_idx, letters_out, reveal_done);
        end
        tests_run++;
        if (got !== exp_bundle()) begin tests_failed++; $display("FAIL preempt_bundle got=%h expected=%h", got, exp_bundle()); end
        $display("[TB] preempt: sel=%0d letters=%h done=%b", sel_idx, letters_out, reveal_done);
    endtask

    task automatic test_drop();
        seq_req = 3'b001;
        repeat (3) frame_pulse();
        seq_req = 3'b000;
        repeat (2) @(negedge clk);
        tests_run++;
        if (SEQ_OUT !== 1'b1 || got !== exp_bundle()) begin
            tests_failed++; $display("FAIL drop_hold got=%h expected=%h", got, exp_bundle());
        end
        frame_pulse();
        tests_run++;
        if (got !== '0) begin tests_failed++; $display("FAIL drop_idle got=%h expected=0", got); end
        $display("[TB] drop: seq_out=%b", SEQ_OUT);
    endtask

    task automatic test_async_reset();
        seq_req = 3'b010;
        repeat (4) frame_pulse();
        tests_run++;
        if (SEQ_OUT !== 1'b1 || sel_idx !== 2'd1) begin
            tests_failed++; $display("FAIL areset_pre seq_out=%b sel=%0d expected 1/1", SEQ_OUT, sel_idx);
        end
        #2 resetN = 1'b0;
        #1;
        tests_run++;
        if (got !== '0) begin tests_failed++; $display("FAIL areset_immediate got=%h expected=0", got); end
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        tests_run++;
        if (got !== '0) begin tests_failed++; $display("FAIL areset_release got=%h expected=0", got); end
        $display("[TB] async reset: outputs=%h", got);
    endtask

    task automatic test_random();
        int errs = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            tests_run++;
            if (got !== exp_bundle()) begin
                tests_failed++; errs++;
                if (errs <= 10) $display("FAIL random_c%0d got=%h expected=%h", cyc, got, exp_bundle());
            end
            if ($urandom_range(0, 23) == 0) seq_req = NS'($urandom);
            startOfFrame = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) rand_contents();
        end
        startOfFrame = 1'b0;
        $display("[TB] random: 800 cycles, %0d mismatching", errs);
    endtask

    initial begin
        test_reset();
        test_priority();
        test_reveal();
        test_preempt();
        test_drop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
